gen_load_start: RTL and testbench

- Layer-level load issuer for the convolution tile loop.
- Takes one conv_start pulse and walks OC_TILES x IC_TILES tiles, with the input-channel tile as the inner loop.
- For each tile it fires start pulses to the in_fm, weight and out_fm loaders, collects their done pulses, and waits for compute_done before moving to the next tile.
- It is the issuing end of the load-done merge path. When ic_idx==0 the out_fm load is replaced by a skip pulse, because partial sums start at zero.

---
 rtl/cnn_ctrl_pkg.sv | 15 +
 rtl/load_flag_tracker.sv | 30 +++
 rtl/gen_load_start.sv | 190 +++++++++++++++++++
 tb/tb_gen_load_start.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cnn_ctrl_pkg.sv
// Shared definitions for the convolution control slice: FSM state encoding
// and default counter width.
package cnn_ctrl_pkg;

  localparam int unsigned CW_DEFAULT = 16;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ISSUE     = 3'd1,
    ST_WAIT_LOAD = 3'd2,
    ST_WAIT_COMP = 3'd3,
    ST_DONE      = 3'd4
  } state_t;

endpackage

// File: rtl/load_flag_tracker.sv
// Sticky "load done" flag for one loader. Cleared (or preset) when a tile
// is issued, set by the loader's done pulse. A done pulse that lands on an
// already-set flag is reported as a duplicate.
module load_flag_tracker (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic preset,
  input  logic done,
  output logic flag,
  output logic dup_err
);

  logic r_flag;

  // Clear has priority so a fresh tile always starts from the preset value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_flag <= 1'b0;
    end else if (clear) begin
      r_flag <= preset;
    end else if (done) begin
      r_flag <= 1'b1;
    end
  end

  assign flag    = r_flag;
  assign dup_err = done & r_flag & ~clear;

endmodule

// File: rtl/gen_load_start.sv
// Layer-level load issuer: walks OC_TILES x IC_TILES tiles (input-channel
// tile innermost), pulses the three loader starts per tile, gathers their
// done pulses and waits for compute_done before advancing. The out_fm load
// is replaced by a skip pulse on ic_idx==0 tiles since partial sums start
// at zero.
module gen_load_start
  import cnn_ctrl_pkg::*;
#(
  parameter int unsigned CW       = CW_DEFAULT,
  parameter int unsigned IC_TILES = 4,
  parameter int unsigned OC_TILES = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          conv_start,
  output logic          in_fm_load_start,
  output logic          weight_load_start,
  output logic          out_fm_load_start,
  output logic          out_fm_skip,
  input  logic          in_fm_load_done,
  input  logic          weight_load_done,
  input  logic          out_fm_load_done,
  input  logic          compute_done,
  output logic [CW-1:0] ic_idx,
  output logic [CW-1:0] oc_idx,
  output logic          busy,
  output logic          layer_done,
  output logic          proto_err
);

  state_t        r_state;
  logic          r_in_start;
  logic          r_wt_start;
  logic          r_out_start;
  logic          r_out_skip;
  logic [CW-1:0] r_ic;
  logic [CW-1:0] r_oc;
  logic          r_busy;
  logic          r_layer_done;
  logic          r_proto_err;

  logic w_issue;
  logic w_wait_load;
  logic w_wait_comp;
  logic w_ic_zero;
  logic w_ic_last;
  logic w_oc_last;
  logic w_in_flag;
  logic w_wt_flag;
  logic w_out_flag;
  logic w_in_dup;
  logic w_wt_dup;
  logic w_out_dup;
  logic w_all_loaded;
  logic w_any_done;
  logic w_stray_done;
  logic w_err;

  assign w_issue     = (r_state == ST_ISSUE);
  assign w_wait_load = (r_state == ST_WAIT_LOAD);
  assign w_wait_comp = (r_state == ST_WAIT_COMP);
  assign w_ic_zero   = (r_ic == '0);
  assign w_ic_last   = (r_ic == CW'(IC_TILES - 1));
  assign w_oc_last   = (r_oc == CW'(OC_TILES - 1));

  load_flag_tracker u_in_flag (
    .clk     (clk),
    .rst     (rst),
    .clear   (w_issue),
    .preset  (1'b0),
    .done    (in_fm_load_done & w_wait_load),
    .flag    (w_in_flag),
    .dup_err (w_in_dup)
  );

  load_flag_tracker u_wt_flag (
    .clk     (clk),
    .rst     (rst),
    .clear   (w_issue),
    .preset  (1'b0),
    .done    (weight_load_done & w_wait_load),
    .flag    (w_wt_flag),
    .dup_err (w_wt_dup)
  );

  load_flag_tracker u_out_flag (
    .clk     (clk),
    .rst     (rst),
    .clear   (w_issue),
    .preset  (w_ic_zero),
    .done    (out_fm_load_done & w_wait_load),
    .flag    (w_out_flag),
    .dup_err (w_out_dup)
  );

  // A done arriving this cycle counts toward completion, so the final done
  // moves the FSM on at the very next edge.
  assign w_all_loaded = (w_in_flag  | in_fm_load_done)  &
                        (w_wt_flag  | weight_load_done) &
                        (w_out_flag | out_fm_load_done);

  assign w_any_done   = in_fm_load_done | weight_load_done | out_fm_load_done;
  assign w_stray_done = w_any_done &
                        ((r_state == ST_IDLE) | w_wait_comp | (r_state == ST_DONE));

  assign w_err = w_in_dup | w_wt_dup | w_out_dup | w_stray_done |
                 (out_fm_load_done & w_ic_zero) |
                 (compute_done & ~w_wait_comp);

  // Tile-walk FSM with registered pulses, indices and status flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_in_start   <= 1'b0;
      r_wt_start   <= 1'b0;
      r_out_start  <= 1'b0;
      r_out_skip   <= 1'b0;
      r_ic         <= '0;
      r_oc         <= '0;
      r_busy       <= 1'b0;
      r_layer_done <= 1'b0;
      r_proto_err  <= 1'b0;
    end else begin
      r_in_start   <= 1'b0;
      r_wt_start   <= 1'b0;
      r_out_start  <= 1'b0;
      r_out_skip   <= 1'b0;
      r_layer_done <= 1'b0;
      if (w_err) begin
        r_proto_err <= 1'b1;
      end
      case (r_state)
        ST_IDLE: begin
          if (conv_start) begin
            r_ic        <= '0;
            r_oc        <= '0;
            r_proto_err <= 1'b0;
            r_busy      <= 1'b1;
            r_state     <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          r_in_start  <= 1'b1;
          r_wt_start  <= 1'b1;
          r_out_start <= ~w_ic_zero;
          r_out_skip  <= w_ic_zero;
          r_state     <= ST_WAIT_LOAD;
        end
        ST_WAIT_LOAD: begin
          if (w_all_loaded) begin
            r_state <= ST_WAIT_COMP;
          end
        end
        ST_WAIT_COMP: begin
          if (compute_done) begin
            if (w_ic_last && w_oc_last) begin
              r_state <= ST_DONE;
            end else if (w_ic_last) begin
              r_ic    <= '0;
              r_oc    <= r_oc + 1'b1;
              r_state <= ST_ISSUE;
            end else begin
              r_ic    <= r_ic + 1'b1;
              r_state <= ST_ISSUE;
            end
          end
        end
        ST_DONE: begin
          r_layer_done <= 1'b1;
          r_busy       <= 1'b0;
          r_state      <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign in_fm_load_start  = r_in_start;
  assign weight_load_start = r_wt_start;
  assign out_fm_load_start = r_out_start;
  assign out_fm_skip       = r_out_skip;
  assign ic_idx            = r_ic;
  assign oc_idx            = r_oc;
  assign busy              = r_busy;
  assign layer_done        = r_layer_done;
  assign proto_err         = r_proto_err;

endmodule

// File: tb/tb_gen_load_start.sv
// Bench for gen_load_start: instance A (IC_TILES=3, OC_TILES=2) and
// instance B (IC_TILES=1, OC_TILES=1). Inputs are driven and outputs
// sampled on the falling clock edge.
module tb_gen_load_start;

  localparam int CW = 16;
  localparam int NI = 2;

  typedef struct {
    int oc;
    int ic;
    bit skip;
    int din;
    int dw;
    int dout;
    int dcomp;
    bit cs_mid;
  } tile_vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [NI-1:0] cs, ifd, wd, ofd, cd;
  logic [NI-1:0] ifs, ws, ofs, skp, bsy, ld, perr;
  logic [CW-1:0] ic_s [NI];
  logic [CW-1:0] oc_s [NI];

  logic ifs_a, ws_a, ofs_a, skp_a, bsy_a, ld_a, perr_a;
  logic ifs_b, ws_b, ofs_b, skp_b, bsy_b, ld_b, perr_b;
  logic [CW-1:0] ic_a, oc_a, ic_b, oc_b;

  int n_pass = 0;
  int n_total = 0;
  int cnt_in [NI];
  int cnt_w [NI];
  int cnt_out [NI];
  int cnt_skip [NI];
  int cnt_ld [NI];

  always #5 clk = ~clk;

  gen_load_start #(.CW(CW), .IC_TILES(3), .OC_TILES(2)) dut_a (
    .clk(clk), .rst(rst), .conv_start(cs[0]),
    .in_fm_load_start(ifs_a), .weight_load_start(ws_a),
    .out_fm_load_start(ofs_a), .out_fm_skip(skp_a),
    .in_fm_load_done(ifd[0]), .weight_load_done(wd[0]),
    .out_fm_load_done(ofd[0]), .compute_done(cd[0]),
    .ic_idx(ic_a), .oc_idx(oc_a), .busy(bsy_a),
    .layer_done(ld_a), .proto_err(perr_a)
  );

  gen_load_start #(.CW(CW), .IC_TILES(1), .OC_TILES(1)) dut_b (
    .clk(clk), .rst(rst), .conv_start(cs[1]),
    .in_fm_load_start(ifs_b), .weight_load_start(ws_b),
    .out_fm_load_start(ofs_b), .out_fm_skip(skp_b),
    .in_fm_load_done(ifd[1]), .weight_load_done(wd[1]),
    .out_fm_load_done(ofd[1]), .compute_done(cd[1]),
    .ic_idx(ic_b), .oc_idx(oc_b), .busy(bsy_b),
    .layer_done(ld_b), .proto_err(perr_b)
  );

  assign ifs  = {ifs_b, ifs_a};
  assign ws   = {ws_b, ws_a};
  assign ofs  = {ofs_b, ofs_a};
  assign skp  = {skp_b, skp_a};
  assign bsy  = {bsy_b, bsy_a};
  assign ld   = {ld_b, ld_a};
  assign perr = {perr_b, perr_a};
  assign ic_s[0] = ic_a;
  assign ic_s[1] = ic_b;
  assign oc_s[0] = oc_a;
  assign oc_s[1] = oc_b;

  function automatic int ic_tiles(input int u);
    return (u == 0) ? 3 : 1;
  endfunction

  function automatic int oc_tiles(input int u);
    return (u == 0) ? 2 : 1;
  endfunction

  task automatic chk(input string name, input int u, input longint act, input longint exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s[dut%0d]: got %0d expected %0d at %0t", name, u, act, exp, $time);
  endtask

  task automatic step();
    @(negedge clk);
    cs = '0; ifd = '0; wd = '0; ofd = '0; cd = '0;
    for (int u = 0; u < NI; u++) begin
      cnt_in[u]   += int'(ifs[u]);
      cnt_w[u]    += int'(ws[u]);
      cnt_out[u]  += int'(ofs[u]);
      cnt_skip[u] += int'(skp[u]);
      cnt_ld[u]   += int'(ld[u]);
    end
  endtask

  task automatic clear_counts(input int u);
    cnt_in[u] = 0; cnt_w[u] = 0; cnt_out[u] = 0; cnt_skip[u] = 0; cnt_ld[u] = 0;
  endtask

  // Called at the negedge on which the trigger (conv_start or the previous
  // compute_done) was driven. Start pulses are due two cycles later.
  task automatic do_tile(input int u, input tile_vec_t v, input bit last, input bit send_comp);
    int last_d;
    step();
    chk("gap_pulses", u, {ifs[u], ws[u], ofs[u], skp[u]}, 0);
    chk("busy_gap", u, bsy[u], 1);
    step();
    chk("in_fm_start", u, ifs[u], 1);
    chk("weight_start", u, ws[u], 1);
    chk("out_fm_start", u, ofs[u], !v.skip);
    chk("out_fm_skip", u, skp[u], v.skip);
    chk("ic_idx", u, ic_s[u], v.ic);
    chk("oc_idx", u, oc_s[u], v.oc);
    last_d = (v.din > v.dw) ? v.din : v.dw;
    if (!v.skip && v.dout > last_d) last_d = v.dout;
    for (int c = 0; c <= last_d; c++) begin
      if (c > 0) step();
      if (v.din == c) ifd[u] = 1'b1;
      if (v.dw == c) wd[u] = 1'b1;
      if (!v.skip && v.dout == c) ofd[u] = 1'b1;
      if (v.cs_mid && c == 1) cs[u] = 1'b1;
    end
    if (!send_comp) begin
      step();
      return;
    end
    for (int k = 1; k <= v.dcomp; k++) begin
      step();
      if (k == v.dcomp) cd[u] = 1'b1;
    end
    if (last) begin
      step();
      chk("layer_done_early", u, ld[u], 0);
      chk("busy_before_end", u, bsy[u], 1);
      step();
      chk("layer_done", u, ld[u], 1);
      chk("busy_at_end", u, bsy[u], 0);
      step();
      chk("layer_done_once", u, ld[u], 0);
    end
  endtask

  // Runs a whole layer from the current negedge and checks pulse totals
  // against the tile list.
  task automatic run_layer(input int u, input tile_vec_t q[$]);
    int exp_skip;
    exp_skip = 0;
    foreach (q[i]) if (q[i].skip) exp_skip++;
    clear_counts(u);
    cs[u] = 1'b1;
    foreach (q[i]) do_tile(u, q[i], i == q.size() - 1, 1'b1);
    chk("total_in_fm_starts", u, cnt_in[u], q.size());
    chk("total_weight_starts", u, cnt_w[u], q.size());
    chk("total_out_fm_starts", u, cnt_out[u], q.size() - exp_skip);
    chk("total_skips", u, cnt_skip[u], exp_skip);
    chk("total_layer_done", u, cnt_ld[u], 1);
    chk("proto_err_clean", u, perr[u], 0);
  endtask

  // Reference tile walk: output-channel tile outer, input-channel inner;
  // the partial-sum load is skipped on the first input-channel tile.
  function automatic void model_layer(input int u, output tile_vec_t q[$]);
    tile_vec_t t;
    q = {};
    for (int o = 0; o < oc_tiles(u); o++) begin
      for (int i = 0; i < ic_tiles(u); i++) begin
        t.oc = o; t.ic = i; t.skip = (i == 0);
        t.din = int'($urandom_range(0, 6));
        t.dw = int'($urandom_range(0, 6));
        t.dout = int'($urandom_range(0, 6));
        t.dcomp = int'($urandom_range(1, 4));
        t.cs_mid = 1'($urandom_range(0, 1));
        q.push_back(t);
      end
    end
  endfunction

  tile_vec_t tbl_a [6] = '{
    '{0, 0, 1'b1, 5, 5, 0, 3, 1'b0},
    '{0, 1, 1'b0, 9, 1, 5, 1, 1'b1},
    '{0, 2, 1'b0, 0, 0, 0, 1, 1'b0},
    '{1, 0, 1'b1, 2, 0, 0, 2, 1'b0},
    '{1, 1, 1'b0, 3, 3, 3, 4, 1'b1},
    '{1, 2, 1'b0, 0, 2, 6, 1, 1'b0}
  };
  tile_vec_t tbl_b [1] = '{'{0, 0, 1'b1, 1, 4, 0, 2, 1'b0}};

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tile_vec_t q[$];
    cs = '0; ifd = '0; wd = '0; ofd = '0; cd = '0;
    rst = 1'b1;
    for (int u = 0; u < NI; u++) clear_counts(u);
    repeat (3) step();
    for (int u = 0; u < NI; u++) begin
      chk("reset_pulses", u, {ifs[u], ws[u], ofs[u], skp[u], ld[u]}, 0);
      chk("reset_busy_err", u, {bsy[u], perr[u]}, 0);
      chk("reset_idx", u, {ic_s[u], oc_s[u]}, 0);
    end
    rst = 1'b0;
    step();
    step();
    chk("no_pulse_after_reset", 0, cnt_in[0] + cnt_w[0] + cnt_skip[0] + cnt_out[0], 0);

    // Table-driven full layer on A (includes conv_start during WAIT_LOAD).
    q = {};
    foreach (tbl_a[i]) q.push_back(tbl_a[i]);
    run_layer(0, q);

    // B: every tile skips out_fm.
    q = {};
    q.push_back(tbl_b[0]);
    run_layer(1, q);

    // Stray done while idle flags an error.
    ofd[1] = 1'b1;
    step();
    step();
    chk("stray_done_idle_err", 1, perr[1], 1);

    // Duplicate weight done: error sticks, layer still completes.
    cs[1] = 1'b1;
    step();
    chk("conv_start_clears_err", 1, perr[1], 0);
    step();
    chk("dup_seq_start", 1, {ifs[1], ws[1], skp[1]}, 3'b111);
    wd[1] = 1'b1;
    step();
    wd[1] = 1'b1;
    chk("dup_not_yet", 1, perr[1], 0);
    step();
    ifd[1] = 1'b1;
    chk("dup_weight_err", 1, perr[1], 1);
    step();
    cd[1] = 1'b1;
    step();
    chk("dup_err_sticky", 1, perr[1], 1);
    step();
    chk("dup_layer_done", 1, ld[1], 1);
    chk("dup_err_after_layer", 1, perr[1], 1);

    // compute_done in the same cycle as the final load done is too early.
    cs[1] = 1'b1;
    step();
    step();
    ifd[1] = 1'b1;
    step();
    wd[1] = 1'b1;
    cd[1] = 1'b1;
    step();
    chk("early_comp_err", 1, perr[1], 1);
    step();
    chk("early_comp_ignored", 1, {bsy[1], ld[1]}, 2'b10);
    cd[1] = 1'b1;
    step();
    step();
    chk("late_comp_layer_done", 1, {bsy[1], ld[1]}, 2'b01);

    // Reset in WAIT_COMP mid-layer on A, with an error already flagged.
    clear_counts(0);
    cs[0] = 1'b1;
    do_tile(0, tbl_a[0], 1'b0, 1'b1);
    do_tile(0, tbl_a[1], 1'b0, 1'b0);
    ifd[0] = 1'b1;
    step();
    chk("pre_rst_err", 0, perr[0], 1);
    chk("pre_rst_ic", 0, ic_s[0], 1);
    #2 rst = 1'b1;
    #1;
    chk("rst_mid_idx", 0, {ic_s[0], oc_s[0]}, 0);
    chk("rst_mid_flags", 0, {bsy[0], perr[0], ld[0], ifs[0], ws[0], ofs[0], skp[0]}, 0);
    step();
    rst = 1'b0;
    clear_counts(0);
    step();
    step();
    chk("rst_release_quiet", 0, cnt_in[0] + cnt_w[0] + cnt_out[0] + cnt_skip[0] + int'(bsy[0]), 0);
    q = {};
    foreach (tbl_a[i]) q.push_back(tbl_a[i]);
    run_layer(0, q);

    // Randomized layers against the reference tile walk.
    for (int r = 0; r < 4; r++) begin
      for (int u = 0; u < NI; u++) begin
        model_layer(u, q);
        run_layer(u, q);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
